// File: rtl/hw_barrier_alloc_ctrl.sv
// Barrier allocator: hands out free hardware barriers and programs their
// trigger/target masks over a write-only peripheral port.
//
//   state  | meaning
//   IDLE   | accepting commands
//   WR1    | first barrier register write (target on ALLOC, trigger clear on FREE)
//   WR2    | second barrier register write (trigger on ALLOC, target clear on FREE)
//   RSP    | presenting result until consumed
module hw_barrier_alloc_ctrl #(
  parameter int unsigned NB_CORES  = 4,
  parameter int unsigned NB_BARR   = 8,
  parameter logic [31:0] BARR_BASE = 32'h0,
  localparam int unsigned IW = $clog2(NB_BARR)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_op_i,
  input  logic [IW-1:0]       cmd_id_i,
  input  logic [NB_CORES-1:0] cmd_trig_mask_i,
  input  logic [NB_CORES-1:0] cmd_tgt_mask_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [IW-1:0]       rsp_id_o,
  output logic                rsp_err_o,
  output logic                bar_req_o,
  output logic [31:0]         bar_add_o,
  output logic                bar_we_n_o,
  output logic [31:0]         bar_wdata_o,
  input  logic                bar_gnt_i,
  output logic [NB_BARR-1:0]  alloc_map_o,
  output logic [IW:0]         nb_free_o
);

  typedef enum logic [1:0] {S_IDLE, S_WR1, S_WR2, S_RSP} state_t;

  localparam logic [IW:0] ONE = 1;

  state_t              state_q, state_d;
  logic [IW-1:0]       id_q, id_d;
  logic [NB_CORES-1:0] trig_q, trig_d;
  logic [NB_CORES-1:0] tgt_q, tgt_d;
  logic                free_q, free_d;
  logic                err_q, err_d;
  logic [NB_BARR-1:0]  map_q, map_d;

  logic [IW-1:0]       free_idx;
  logic [31:0]         row_base;

  always_comb begin
    free_idx = '0;
    for (int i = NB_BARR - 1; i >= 0; i--) begin
      if (!map_q[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    nb_free_o = '0;
    for (int i = 0; i < NB_BARR; i++) begin
      if (!map_q[i]) nb_free_o = nb_free_o + ONE;
    end
  end

  assign row_base    = BARR_BASE + (32'(id_q) << 5);
  assign alloc_map_o = map_q;
  assign bar_we_n_o  = 1'b0;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    trig_d      = trig_q;
    tgt_d       = tgt_q;
    free_d      = free_q;
    err_d       = err_q;
    map_d       = map_q;
    cmd_ready_o = 1'b0;
    bar_req_o   = 1'b0;
    bar_add_o   = '0;
    bar_wdata_o = '0;
    rsp_valid_o = 1'b0;
    rsp_id_o    = '0;
    rsp_err_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          free_d = cmd_op_i;
          trig_d = cmd_trig_mask_i;
          tgt_d  = cmd_tgt_mask_i;
          if (!cmd_op_i) begin
            if ((&map_q) || (cmd_trig_mask_i == '0)) begin
              err_d   = 1'b1;
              id_d    = '0;
              state_d = S_RSP;
            end else begin
              err_d   = 1'b0;
              id_d    = free_idx;
              state_d = S_WR1;
            end
          end else begin
            id_d    = cmd_id_i;
            err_d   = !map_q[cmd_id_i];
            state_d = map_q[cmd_id_i] ? S_WR1 : S_RSP;
          end
        end
      end
      // ALLOC arms the target before the trigger; FREE disarms the trigger first.
      S_WR1: begin
        bar_req_o   = 1'b1;
        bar_add_o   = row_base + (free_q ? 32'h0 : 32'hC);
        bar_wdata_o = free_q ? 32'h0 : 32'(tgt_q);
        if (bar_gnt_i) state_d = S_WR2;
      end
      S_WR2: begin
        bar_req_o   = 1'b1;
        bar_add_o   = row_base + (free_q ? 32'hC : 32'h0);
        bar_wdata_o = free_q ? 32'h0 : 32'(trig_q);
        if (bar_gnt_i) begin
          map_d[id_q] = !free_q;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        rsp_valid_o = 1'b1;
        rsp_id_o    = id_q;
        rsp_err_o   = err_q;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      trig_q  <= '0;
      tgt_q   <= '0;
      free_q  <= 1'b0;
      err_q   <= 1'b0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      trig_q  <= trig_d;
      tgt_q   <= tgt_d;
      free_q  <= free_d;
      err_q   <= err_d;
      map_q   <= map_d;
    end
  end

endmodule

// File: tb/tb_hw_barrier_alloc_ctrl.sv
// Bench for hw_barrier_alloc_ctrl: a transaction-level model (pending write
// queue + allocation map) is compared against the DUT every cycle.
module tb_hw_barrier_alloc_ctrl;

  localparam int NC = 4;
  localparam int NB = 8;
  localparam int IW = 3;
  localparam logic [31:0] BASE = 32'h0;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_op_i;
  logic [IW-1:0] cmd_id_i;
  logic [NC-1:0] cmd_trig_mask_i;
  logic [NC-1:0] cmd_tgt_mask_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [IW-1:0] rsp_id_o;
  logic          rsp_err_o;
  logic          bar_req_o;
  logic [31:0]   bar_add_o;
  logic          bar_we_n_o;
  logic [31:0]   bar_wdata_o;
  logic          bar_gnt_i;
  logic [NB-1:0] alloc_map_o;
  logic [IW:0]   nb_free_o;

  always #5 clk_i = ~clk_i;

  hw_barrier_alloc_ctrl #(.NB_CORES(NC), .NB_BARR(NB), .BARR_BASE(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_id_i(cmd_id_i), .cmd_trig_mask_i(cmd_trig_mask_i), .cmd_tgt_mask_i(cmd_tgt_mask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_err_o(rsp_err_o), .bar_req_o(bar_req_o), .bar_add_o(bar_add_o),
    .bar_we_n_o(bar_we_n_o), .bar_wdata_o(bar_wdata_o), .bar_gnt_i(bar_gnt_i),
    .alloc_map_o(alloc_map_o), .nb_free_o(nb_free_o)
  );

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: idle flag, queue of bus writes still owed, result of current command.
  bit            m_idle;
  logic [31:0]   q_add[$];
  logic [31:0]   q_dat[$];
  int            m_id;
  bit            m_err;
  bit            m_alloc;
  logic [NB-1:0] m_map;

  function automatic void model_edge();
    if (rst_i) begin
      m_idle = 1'b1;
      q_add.delete();
      q_dat.delete();
      m_map = '0;
      m_id  = 0;
      m_err = 1'b0;
      return;
    end
    if (m_idle) begin
      if (cmd_valid_i) begin
        int n;
        n       = -1;
        m_idle  = 1'b0;
        m_alloc = !cmd_op_i;
        if (m_alloc) begin
          for (int i = NB - 1; i >= 0; i--) if (!m_map[i]) n = i;
          if (n < 0 || cmd_trig_mask_i == 0) begin
            m_err = 1'b1;
            m_id  = 0;
          end else begin
            m_err = 1'b0;
            m_id  = n;
            q_add.push_back(BASE + 32'(32 * n + 12)); q_dat.push_back(32'(cmd_tgt_mask_i));
            q_add.push_back(BASE + 32'(32 * n));      q_dat.push_back(32'(cmd_trig_mask_i));
          end
        end else begin
          m_id  = int'(cmd_id_i);
          m_err = !m_map[m_id];
          if (!m_err) begin
            q_add.push_back(BASE + 32'(32 * m_id));      q_dat.push_back(32'h0);
            q_add.push_back(BASE + 32'(32 * m_id + 12)); q_dat.push_back(32'h0);
          end
        end
      end
    end else if (q_add.size() > 0) begin
      if (bar_gnt_i) begin
        void'(q_add.pop_front());
        void'(q_dat.pop_front());
        if (q_add.size() == 0) m_map[m_id] = m_alloc;
      end
    end else if (rsp_ready_i) begin
      m_idle = 1'b1;
    end
  endfunction

  always @(negedge clk_i) begin
    if (chk_en) begin
      cmp("cmd_ready", 32'(cmd_ready_o), 32'(m_idle));
      cmp("bar_req", 32'(bar_req_o), 32'(q_add.size() > 0));
      cmp("bar_we_n", 32'(bar_we_n_o), 32'h0);
      cmp("bar_add", bar_add_o, (q_add.size() > 0) ? q_add[0] : 32'h0);
      cmp("bar_wdata", bar_wdata_o, (q_dat.size() > 0) ? q_dat[0] : 32'h0);
      cmp("rsp_valid", 32'(rsp_valid_o), 32'(!m_idle && q_add.size() == 0));
      if (!m_idle && q_add.size() == 0) begin
        cmp("rsp_id", 32'(rsp_id_o), 32'(m_id));
        cmp("rsp_err", 32'(rsp_err_o), 32'(m_err));
      end
      cmp("alloc_map", 32'(alloc_map_o), 32'(m_map));
      cmp("nb_free", 32'(nb_free_o), 32'(NB - $countones(m_map)));
    end
  end

  // Inputs are applied 2 time units after an edge and held through the next edge.
  task automatic drive(input bit v, input bit op, input int id, input logic [NC-1:0] trig,
                       input logic [NC-1:0] tgt, input bit gnt, input bit rdy, input bit rst);
    cmd_valid_i     = v;
    cmd_op_i        = op;
    cmd_id_i        = IW'(id);
    cmd_trig_mask_i = trig;
    cmd_tgt_mask_i  = tgt;
    bar_gnt_i       = gnt;
    rsp_ready_i     = rdy;
    rst_i           = rst;
    @(posedge clk_i);
    model_edge();
    #2;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b1, 1'b1);
    chk_en = 1'b1;
    cmp("rst_cmd_ready", 32'(cmd_ready_o), 1);
    cmp("rst_map", 32'(alloc_map_o), 0);
    cmp("rst_nb_free", 32'(nb_free_o), 8);
    cmp("rst_bar_req", 32'(bar_req_o), 0);
    cmp("rst_rsp_valid", 32'(rsp_valid_o), 0);
    cmp("rst_rsp_err", 32'(rsp_err_o), 0);
    cmp("rst_rsp_id", 32'(rsp_id_o), 0);

    // first allocation, full-speed handshakes
    drive(1'b1, 1'b0, 0, 4'b0011, 4'b1100, 1'b1, 1'b1, 1'b0);
    cmp("a0_wr1_req", 32'(bar_req_o), 1);
    cmp("a0_wr1_add", bar_add_o, 32'h0C);
    cmp("a0_wr1_dat", bar_wdata_o, 32'hC);
    nop();
    cmp("a0_wr2_add", bar_add_o, 32'h00);
    cmp("a0_wr2_dat", bar_wdata_o, 32'h3);
    nop();
    cmp("a0_rsp_valid", 32'(rsp_valid_o), 1);
    cmp("a0_rsp_id", 32'(rsp_id_o), 0);
    cmp("a0_rsp_err", 32'(rsp_err_o), 0);
    cmp("a0_map", 32'(alloc_map_o), 32'h01);
    cmp("a0_nb_free", 32'(nb_free_o), 7);
    nop();

    // fill the rest, then one more that must be refused
    for (int i = 1; i < NB; i++) begin
      drive(1'b1, 1'b0, 0, 4'b0001, 4'b0010, 1'b1, 1'b1, 1'b0);
      nop();
      nop();
      cmp("fill_rsp_id", 32'(rsp_id_o), 32'(i));
      nop();
    end
    cmp("full_map", 32'(alloc_map_o), 32'hFF);
    cmp("full_nb_free", 32'(nb_free_o), 0);
    drive(1'b1, 1'b0, 0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0);
    cmp("full_err_valid", 32'(rsp_valid_o), 1);
    cmp("full_err", 32'(rsp_err_o), 1);
    cmp("full_err_id", 32'(rsp_id_o), 0);
    cmp("full_err_req", 32'(bar_req_o), 0);
    nop();

    // free barrier 3 and reallocate it
    drive(1'b1, 1'b1, 3, '0, '0, 1'b1, 1'b1, 1'b0);
    cmp("f3_wr1_add", bar_add_o, 32'h60);
    cmp("f3_wr1_dat", bar_wdata_o, 32'h0);
    nop();
    cmp("f3_wr2_add", bar_add_o, 32'h6C);
    nop();
    cmp("f3_map", 32'(alloc_map_o), 32'hF7);
    cmp("f3_rsp_id", 32'(rsp_id_o), 3);
    nop();
    drive(1'b1, 1'b0, 0, 4'b0101, 4'b1010, 1'b1, 1'b1, 1'b0);
    nop();
    nop();
    cmp("re3_rsp_id", 32'(rsp_id_o), 3);
    cmp("re3_map", 32'(alloc_map_o), 32'hFF);
    nop();

    // free 5, then the error cases: double free and empty trigger mask
    drive(1'b1, 1'b1, 5, '0, '0, 1'b1, 1'b1, 1'b0);
    nop(); nop(); nop();
    drive(1'b1, 1'b1, 5, '0, '0, 1'b1, 1'b1, 1'b0);
    cmp("ff5_err", 32'(rsp_err_o), 1);
    cmp("ff5_id", 32'(rsp_id_o), 5);
    cmp("ff5_req", 32'(bar_req_o), 0);
    cmp("ff5_map", 32'(alloc_map_o), 32'hDF);
    nop();
    drive(1'b1, 1'b0, 0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    cmp("trig0_err", 32'(rsp_err_o), 1);
    cmp("trig0_id", 32'(rsp_id_o), 0);
    cmp("trig0_req", 32'(bar_req_o), 0);
    cmp("trig0_map", 32'(alloc_map_o), 32'hDF);
    nop();

    // grant and response back-pressure with a queued command waiting
    drive(1'b1, 1'b0, 0, 4'b1001, 4'b0110, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 0, '0, '0, 1'b0, 1'b1, 1'b0);
    cmp("stall_add", bar_add_o, 32'hAC);
    cmp("stall_dat", bar_wdata_o, 32'h6);
    cmp("stall_ready", 32'(cmd_ready_o), 0);
    drive(1'b1, 1'b1, 0, '0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 0, '0, '0, 1'b1, 1'b0, 1'b0);
    cmp("bp_rsp_valid", 32'(rsp_valid_o), 1);
    cmp("bp_rsp_id", 32'(rsp_id_o), 5);
    drive(1'b1, 1'b1, 0, '0, '0, 1'b1, 1'b1, 1'b0);
    cmp("bp_after_valid", 32'(rsp_valid_o), 0);
    cmp("bp_after_ready", 32'(cmd_ready_o), 1);
    drive(1'b1, 1'b1, 0, '0, '0, 1'b1, 1'b1, 1'b0);
    nop(); nop(); nop();

    // reset while the second write is outstanding
    drive(1'b1, 1'b0, 0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b1, 1'b0);
    cmp("rw2_add", bar_add_o, 32'h00);
    cmp("rw2_dat", bar_wdata_o, 32'h1);
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0, 1'b1, 1'b1);
    cmp("rw2_req", 32'(bar_req_o), 0);
    cmp("rw2_map", 32'(alloc_map_o), 0);
    cmp("rw2_ready", 32'(cmd_ready_o), 1);
    nop();

    for (int c = 0; c < 4000; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4, int'($urandom_range(0, NB - 1)),
            NC'($urandom_range(0, 15)), NC'($urandom_range(0, 15)),
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 299) == 0);
    end

    @(negedge clk_i);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
